// File: rtl/scan_loader_pkg.sv
// Shared types and geometry helpers for the serial-scan texture loader.
package scan_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SHIFT,
        WAIT_LATCH
    } state_e;

    localparam logic MODE_FULL = 1'b1;
    localparam logic MODE_DATA = 1'b0;

    // Number of shift ticks carrying payload for a given frame mode.
    function automatic int unsigned frame_ticks(input int unsigned addr_w,
                                                input int unsigned data_w,
                                                input int unsigned lanes,
                                                input logic        mode);
        return (mode == MODE_FULL) ? (addr_w + data_w) / lanes : data_w / lanes;
    endfunction

endpackage

// File: rtl/scan_wr_slot.sv
// Single-entry valid/ready write register: accepts a commit when empty or
// draining this cycle, otherwise drops it and raises a sticky overflow.
module scan_wr_slot #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_i,
    input  logic [ADDR_W-1:0] commit_addr_i,
    input  logic [DATA_W-1:0] commit_data_i,
    input  logic              err_clr_i,
    input  logic              wr_ready_i,
    output logic              accept_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  count_q;
    logic              slot_free;
    logic              fire;

    assign fire      = valid_q && wr_ready_i;
    assign slot_free = !valid_q || wr_ready_i;
    assign accept_o  = commit_i && slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (accept_o) begin
                valid_q <= 1'b1;
                addr_q  <= commit_addr_i;
                data_q  <= commit_data_i;
            end else if (fire) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (commit_i && !slot_free) begin
                overflow_q <= 1'b1;
            end else if (err_clr_i) begin
                overflow_q <= 1'b0;
            end

            if (fire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign wr_valid_o = valid_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign overflow_o = overflow_q;
    assign wr_count_o = count_q;

endmodule

// File: rtl/scan_texture_loader.sv
// Serial-scan receiver: assembles address/data frames from LANES scan lanes
// and hands each latched frame to the texture RAM write port.
module scan_texture_loader
    import scan_loader_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int LANES  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_shift,
    input  logic              scan_latch,
    input  logic [LANES-1:0]  scan_in,
    input  logic              err_clr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int FW         = ADDR_W + DATA_W;
    localparam int FULL_TICKS = int'(frame_ticks(ADDR_W, DATA_W, LANES, MODE_FULL));
    localparam int DATA_TICKS = int'(frame_ticks(ADDR_W, DATA_W, LANES, MODE_DATA));
    localparam int TCNT_W     = $clog2(FULL_TICKS + 1);

    generate
        if ((FW % LANES) != 0 || (DATA_W % LANES) != 0) begin : g_bad_geom
            $error("scan_texture_loader: frame widths must be multiples of LANES");
        end
    endgenerate

    state_e            state_q;
    logic [TCNT_W-1:0] cnt_q;
    logic [FW-1:0]     sr_q;
    logic              mode_q;
    logic              frame_err_q;
    logic [ADDR_W-1:0] last_addr_q;

    logic [FW-1:0]     sr_shifted;
    logic              err_ev;
    logic              commit_ev;
    logic              accept;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;

    // Data always lands in the low DATA_W bits, so both frame modes share one register.
    always_comb begin
        sr_shifted  = (sr_q << LANES) | FW'(scan_in);
        err_ev      = 1'b0;
        commit_ev   = 1'b0;
        commit_addr = (mode_q == MODE_FULL) ? sr_q[FW-1:DATA_W]
                                            : last_addr_q + ADDR_W'(1);
        commit_data = sr_q[DATA_W-1:0];
        if (state_q != IDLE) begin
            if (scan_shift && scan_latch) begin
                err_ev = 1'b1;
            end else if (scan_latch) begin
                if (state_q == WAIT_LATCH) begin
                    commit_ev = 1'b1;
                end else begin
                    err_ev = 1'b1;
                end
            end else if (scan_shift && state_q == WAIT_LATCH) begin
                err_ev = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            mode_q  <= MODE_DATA;
        end else if (err_ev) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_shift && scan_in[0]) begin
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (scan_shift) begin
                        mode_q  <= scan_in[0];
                        cnt_q   <= (scan_in[0] == MODE_FULL) ? TCNT_W'(FULL_TICKS)
                                                             : TCNT_W'(DATA_TICKS);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (scan_shift) begin
                        sr_q  <= sr_shifted;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == TCNT_W'(1)) begin
                            state_q <= WAIT_LATCH;
                        end
                    end
                end
                WAIT_LATCH: begin
                    if (commit_ev) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            last_addr_q <= '1;
        end else begin
            if (err_ev) begin
                frame_err_q <= 1'b1;
            end else if (err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (accept) begin
                last_addr_q <= commit_addr;
            end
        end
    end

    scan_wr_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot (
        .clk           (clk),
        .rst           (rst),
        .commit_i      (commit_ev),
        .commit_addr_i (commit_addr),
        .commit_data_i (commit_data),
        .err_clr_i     (err_clr),
        .wr_ready_i    (wr_ready),
        .accept_o      (accept),
        .wr_valid_o    (wr_valid),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .overflow_o    (overflow),
        .wr_count_o    (wr_count)
    );

    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_scan_texture_loader.sv
// Directed bench for scan_texture_loader: a single-lane default instance and a
// 4-lane, 12-bit-address instance driven from per-feature tasks.
module tb_scan_texture_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, err_clr;
    logic        sh1, la1, rdy1;
    logic [0:0]  in1;
    logic        sh2, la2, rdy2;
    logic [3:0]  in2;

    logic        v1, busy1, fe1, ov1;
    logic [10:0] a1;
    logic [7:0]  d1;
    logic [15:0] cnt1;
    logic        v2, busy2, fe2, ov2;
    logic [11:0] a2;
    logic [7:0]  d2;
    logic [15:0] cnt2;

    int n_vec = 0;
    int n_err = 0;

    scan_texture_loader dut1 (
        .clk(clk), .rst(rst), .scan_shift(sh1), .scan_latch(la1), .scan_in(in1),
        .err_clr(err_clr), .wr_valid(v1), .wr_ready(rdy1), .wr_addr(a1), .wr_data(d1),
        .busy(busy1), .frame_err(fe1), .overflow(ov1), .wr_count(cnt1)
    );

    scan_texture_loader #(.ADDR_W(12), .DATA_W(8), .LANES(4), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .scan_shift(sh2), .scan_latch(la2), .scan_in(in2),
        .err_clr(err_clr), .wr_valid(v2), .wr_ready(rdy2), .wr_addr(a2), .wr_data(d2),
        .busy(busy2), .frame_err(fe2), .overflow(ov2), .wr_count(cnt2)
    );

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic cyc(input bit sel, input bit s, input bit l, input logic [3:0] din);
        if (!sel) begin
            sh1 = s; la1 = l; in1 = din[0];
        end else begin
            sh2 = s; la2 = l; in2 = din;
        end
        @(negedge clk);
        sh1 = 1'b0; la1 = 1'b0; in1 = 1'b0;
        sh2 = 1'b0; la2 = 1'b0; in2 = 4'h0;
        err_clr = 1'b0;
    endtask

    task automatic send_bits1(input logic [18:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b1, 1'b0, {3'b000, v[i]});
    endtask

    task automatic shift_full1(input logic [10:0] addr, input logic [7:0] data);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        send_bits1({addr, data}, 19);
    endtask

    task automatic shift_data1(input logic [7:0] data);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        send_bits1({11'h000, data}, 8);
    endtask

    task automatic latch1();
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
    endtask

    task automatic idle1();
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle1();
        idle1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle1();
        n_vec++; if ({v1, busy1, fe1, ov1} !== 4'b0000) begin n_err++; $display("FAIL reset_flags1: got %b want 0000", {v1, busy1, fe1, ov1}); end
        n_vec++; if ({a1, d1} !== 19'h0) begin n_err++; $display("FAIL reset_addr_data1: got %h/%h want 000/00", a1, d1); end
        n_vec++; if (cnt1 !== 16'h0) begin n_err++; $display("FAIL reset_count1: got %0d want 0", cnt1); end
        n_vec++; if ({v2, busy2, fe2, ov2, cnt2} !== 20'h0) begin n_err++; $display("FAIL reset_dut2: got %b/%0d want 0000/0", {v2, busy2, fe2, ov2}, cnt2); end
        idle1();
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_full_frame();
        rdy1 = 1'b1;
        shift_full1(11'h155, 8'hA5);
        n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy1); end
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL full_no_early_valid: got %b want 0", v1); end
        latch1();
        $display("write addr=%h data=%h valid=%b", a1, d1, v1);
        n_vec++; if (v1 !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", v1); end
        n_vec++; if (a1 !== 11'h155) begin n_err++; $display("FAIL full_addr: got %h want 155", a1); end
        n_vec++; if (d1 !== 8'hA5) begin n_err++; $display("FAIL full_data: got %h want a5", d1); end
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL full_busy_after: got %b want 0", busy1); end
        idle1();
        n_vec++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL full_count: got %0d want 1", cnt1); end
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL full_valid_drop: got %b want 0", v1); end
    endtask

    task automatic test_burst();
        for (int k = 1; k <= 3; k++) begin
            shift_data1(8'(k));
            latch1();
            $display("write addr=%h data=%h", a1, d1);
            n_vec++; if (a1 !== 11'(11'h155 + k)) begin n_err++; $display("FAIL burst_addr%0d: got %h want %h", k, a1, 11'(11'h155 + k)); end
            n_vec++; if (d1 !== 8'(k)) begin n_err++; $display("FAIL burst_data%0d: got %h want %h", k, d1, 8'(k)); end
            idle1();
        end
        n_vec++; if (cnt1 !== 16'd4) begin n_err++; $display("FAIL burst_count: got %0d want 4", cnt1); end
        do_reset();
        shift_data1(8'h7E);
        latch1();
        $display("write addr=%h data=%h", a1, d1);
        n_vec++; if (a1 !== 11'h000 || d1 !== 8'h7E) begin n_err++; $display("FAIL data_after_reset: got %h/%h want 000/7e", a1, d1); end
        idle1();
        shift_full1(11'h7FF, 8'h11);
        latch1();
        idle1();
        shift_data1(8'h22);
        latch1();
        $display("write addr=%h data=%h", a1, d1);
        n_vec++; if (a1 !== 11'h000 || d1 !== 8'h22) begin n_err++; $display("FAIL addr_wrap: got %h/%h want 000/22", a1, d1); end
        idle1();
    endtask

    task automatic test_multilane();
        logic [3:0] nib [5] = '{4'hA, 4'hB, 4'hC, 4'h3, 4'hC};
        rdy2 = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 4'h1);
        cyc(1'b1, 1'b1, 1'b0, 4'h1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, nib[i]);
        n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL lanes_busy: got %b want 1", busy2); end
        cyc(1'b1, 1'b0, 1'b1, 4'h0);
        $display("lane4 write addr=%h data=%h", a2, d2);
        n_vec++; if (v2 !== 1'b1 || a2 !== 12'hABC || d2 !== 8'h3C) begin n_err++; $display("FAIL lanes_write: got %b/%h/%h want 1/abc/3c", v2, a2, d2); end
        idle1();
        n_vec++; if (cnt2 !== 16'd1) begin n_err++; $display("FAIL lanes_count: got %0d want 1", cnt2); end
    endtask

    task automatic test_errors();
        logic [15:0] c0;
        rdy1 = 1'b1;
        c0 = cnt1;
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        send_bits1(19'h2AAAA, 10);
        latch1();
        n_vec++; if (fe1 !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL early_latch: got err=%b busy=%b want 1/0", fe1, busy1); end
        idle1();
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL early_latch_nowrite: got %b want 0", v1); end
        err_clr = 1'b1;
        idle1();
        n_vec++; if (fe1 !== 1'b0) begin n_err++; $display("FAIL err_clr1: got %b want 0", fe1); end
        shift_full1(11'h0AA, 8'h55);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        n_vec++; if (fe1 !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL extra_shift: got err=%b busy=%b want 1/0", fe1, busy1); end
        latch1();
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL extra_shift_nowrite: got %b want 0", v1); end
        err_clr = 1'b1;
        idle1();
        n_vec++; if (fe1 !== 1'b0) begin n_err++; $display("FAIL err_clr2: got %b want 0", fe1); end
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        send_bits1(19'h7, 3);
        err_clr = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 4'h0);
        n_vec++; if (fe1 !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL shift_latch_same: got err=%b busy=%b want 1/0", fe1, busy1); end
        err_clr = 1'b1;
        idle1();
        n_vec++; if (fe1 !== 1'b0) begin n_err++; $display("FAIL err_clr3: got %b want 0", fe1); end
        n_vec++; if (cnt1 !== c0) begin n_err++; $display("FAIL err_no_writes: got %0d want %0d", cnt1, c0); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy1 = 1'b0;
        shift_full1(11'h010, 8'h44);
        latch1();
        $display("write addr=%h data=%h (stalled)", a1, d1);
        n_vec++; if (v1 !== 1'b1 || a1 !== 11'h010) begin n_err++; $display("FAIL bp_first: got %b/%h want 1/010", v1, a1); end
        shift_full1(11'h020, 8'h55);
        latch1();
        n_vec++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %b want 1", ov1); end
        n_vec++; if (v1 !== 1'b1 || a1 !== 11'h010 || d1 !== 8'h44) begin n_err++; $display("FAIL bp_held: got %b/%h/%h want 1/010/44", v1, a1, d1); end
        n_vec++; if (cnt1 !== 16'd0) begin n_err++; $display("FAIL bp_count0: got %0d want 0", cnt1); end
        rdy1 = 1'b1;
        idle1();
        n_vec++; if (cnt1 !== 16'd1 || v1 !== 1'b0) begin n_err++; $display("FAIL bp_release: got %0d/%b want 1/0", cnt1, v1); end
        shift_data1(8'h66);
        latch1();
        $display("write addr=%h data=%h", a1, d1);
        n_vec++; if (a1 !== 11'h011) begin n_err++; $display("FAIL bp_last_addr: got %h want 011", a1); end
        n_vec++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %b want 1", ov1); end
        err_clr = 1'b1;
        idle1();
        n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL bp_clear: got %b want 0", ov1); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0;
        c0 = cnt1;
        rdy1 = 1'b0;
        shift_full1(11'h100, 8'h01);
        latch1();
        shift_full1(11'h200, 8'h02);
        rdy1 = 1'b1;
        latch1();
        $display("write addr=%h data=%h (back-to-back)", a1, d1);
        n_vec++; if (v1 !== 1'b1 || a1 !== 11'h200 || d1 !== 8'h02) begin n_err++; $display("FAIL b2b_second: got %b/%h/%h want 1/200/02", v1, a1, d1); end
        n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL b2b_no_overflow: got %b want 0", ov1); end
        n_vec++; if (cnt1 !== 16'(c0 + 1)) begin n_err++; $display("FAIL b2b_count1: got %0d want %0d", cnt1, c0 + 1); end
        idle1();
        n_vec++; if (cnt1 !== 16'(c0 + 2) || v1 !== 1'b0) begin n_err++; $display("FAIL b2b_count2: got %0d/%b want %0d/0", cnt1, v1, c0 + 2); end
    endtask

    task automatic test_reset_mid();
        rdy1 = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1);
        send_bits1(19'h55, 7);
        rst = 1'b1;
        idle1();
        rst = 1'b0;
        n_vec++; if (busy1 !== 1'b0 || v1 !== 1'b0) begin n_err++; $display("FAIL mid_reset: got busy=%b valid=%b want 0/0", busy1, v1); end
        latch1();
        n_vec++; if (v1 !== 1'b0 || fe1 !== 1'b0) begin n_err++; $display("FAIL mid_reset_nowrite: got %b/%b want 0/0", v1, fe1); end
        shift_full1(11'h3C3, 8'h5A);
        latch1();
        $display("write addr=%h data=%h", a1, d1);
        n_vec++; if (v1 !== 1'b1 || a1 !== 11'h3C3 || d1 !== 8'h5A) begin n_err++; $display("FAIL mid_reset_clean: got %b/%h/%h want 1/3c3/5a", v1, a1, d1); end
        idle1();
        n_vec++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL mid_reset_count: got %0d want 1", cnt1); end
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        sh1 = 1'b0; la1 = 1'b0; in1 = 1'b0; rdy1 = 1'b0;
        sh2 = 1'b0; la2 = 1'b0; in2 = 4'h0; rdy2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_burst();
        test_multilane();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_texture_loader.md
Name: scan_texture_loader

Overview:
- Single-clock, parametrised serial-scan receiver for loading texture memory.
- Shifts 1..N parallel scan lanes into address+data frames. Supports full frames (address+data) and data-only burst frames, which auto-increment the address.
- Commits each frame on a latch strobe and presents it as a valid/ready write to the texture RAM port.
- Sits between the pad-side scan synchroniser (which produces single-cycle shift/latch pulses) and the texture memory.

Parameters:
- ADDR_W, 11, texture address width (2048 entries)
- DATA_W, 8, texel width
- LANES, 1, parallel scan lanes per shift tick; (ADDR_W+DATA_W) % LANES must be 0, else elaboration error
- CNT_W, 16, width of committed-write counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- scan_shift  in  1  single-cycle shift-tick pulse, synchronous to clk
- scan_latch  in  1  single-cycle commit pulse
- scan_in  in  LANES  serial data lanes, sampled when scan_shift=1
- err_clr  in  1  clears sticky error flags
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- busy  out  1  FSM not IDLE
- frame_err  out  1  sticky protocol error
- overflow  out  1  sticky: frame dropped because output was still pending
- wr_count  out  CNT_W  number of accepted writes (valid&&ready), wraps

Behaviour:
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, busy=0, frame_err=0, overflow=0, wr_count=0. Internal last_addr resets to all-ones. FSM resets to IDLE. Reset mid-frame discards the partial frame.
- Frame geometry:
  - F = ADDR_W+DATA_W for a full frame, DATA_W for a data-only frame.
  - The frame takes F/LANES ticks; data-only frames also require DATA_W % LANES = 0, else elaboration error.
  - Each tick shifts in LANES bits, MSB-first; scan_in[LANES-1] is the most significant bit of the group.
  - In a full frame, the address occupies the upper ADDR_W bits.
- FSM, evaluated only on cycles with scan_shift or scan_latch:
  - IDLE: shift with scan_in[0]=1 -> HDR. Shift with scan_in[0]=0 -> stay (idle fill). Latch -> ignored.
  - HDR: shift samples scan_in[0] as the mode bit (1=full, 0=data-only), loads the tick count, -> SHIFT. Latch -> frame_err, -> IDLE.
  - SHIFT: each shift decrements the count; on the last tick -> WAIT_LATCH. Latch before complete -> frame_err, discard, -> IDLE.
  - WAIT_LATCH: latch -> commit, -> IDLE. An extra shift -> frame_err, discard, -> IDLE; that tick is not a start bit.
- Simultaneous scan_shift and scan_latch in the same cycle, in any state other than IDLE: frame_err, discard, -> IDLE. In IDLE the shift is processed as above and the latch is ignored.
- Commit:
  - Address is the shifted address for a full frame, or last_addr+1 mod 2^ADDR_W for data-only (wraps 0x7FF -> 0x000).
  - If the output is free (!wr_valid, or wr_valid&&wr_ready in the same cycle): wr_valid/wr_addr/wr_data are updated at the next edge, giving latency 1 cycle from the latch, and last_addr takes the committed address.
  - Otherwise the frame is dropped, overflow is set, and last_addr is unchanged.
- Handshake:
  - wr_addr/wr_data are held stable while wr_valid && !wr_ready.
  - wr_valid drops the cycle after acceptance unless a new commit arrives in the accepting cycle, which gives back-to-back writes.
  - wr_count increments on each valid&&ready.
- err_clr clears frame_err and overflow. An error event in the same cycle as err_clr wins (the flag stays set).
- busy is 1 in HDR, SHIFT and WAIT_LATCH.

Decomposition:
- Package scan_loader_pkg holds:
  - the state enum typedef (IDLE, HDR, SHIFT, WAIT_LATCH)
  - mode-bit constants MODE_FULL=1, MODE_DATA=0
  - a function computing tick counts from ADDR_W/DATA_W/LANES
- One natural sub-module, scan_wr_slot: the single-entry valid/ready output register with overflow detect.

Test Plan:
- Full frame, defaults: start=1, mode=1, addr 0x155, data 0xA5 MSB-first (19 ticks), then latch -> wr_valid on the next cycle with wr_addr=0x155, wr_data=0xA5; wr_count=1 after ready.
- Burst: the full frame above, then three data-only frames 0x01, 0x02, 0x03 -> writes at 0x156, 0x157, 0x158. Data-only frame right after reset with data 0x7E -> write at 0x000. Full frame at 0x7FF, then data-only -> write at 0x000.
- Multi-lane: ADDR_W=12, DATA_W=8, LANES=4, full frame addr 0xABC, data 0x3C in 5 ticks (nibbles A,B,C,3,C) -> wr_addr=0xABC, wr_data=0x3C.
- Protocol errors:
  - latch after 10 of 19 ticks -> frame_err=1, no write, busy=0
  - 20th shift -> frame_err
  - shift+latch in the same cycle in SHIFT -> frame_err
  - err_clr -> 0
- Backpressure: wr_ready=0, commit two frames -> first held stable, second dropped, overflow=1, wr_count=0. Raise ready -> one write, wr_count=1.
- Reset mid-SHIFT after 7 ticks -> busy=0, no write. The following clean frame writes correctly.
